// File: rtl/hella_cache_arbiter_if.sv
// rtl/hella_cache_arbiter_if.sv - hella cache request/stage-1/stage-2/response port bundle
interface hella_cache_arbiter_if #(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 64,
    parameter int TAG_BITS  = 7
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [TAG_BITS-1:0]    req_tag;
    logic [4:0]             req_cmd;
    logic [2:0]             req_typ;
    logic [DATA_BITS-1:0]   s1_data;
    logic [DATA_BITS/8-1:0] s1_data_mask;
    logic                   s1_kill;
    logic                   s2_nack;
    logic                   rsp_valid;
    logic [TAG_BITS-1:0]    rsp_tag;
    logic [2:0]             rsp_typ;
    logic [DATA_BITS-1:0]   rsp_data;

    modport master (
        output req_valid, req_addr, req_tag, req_cmd, req_typ,
        output s1_data, s1_data_mask, s1_kill,
        input  req_ready, s2_nack, rsp_valid, rsp_tag, rsp_typ, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_tag, req_cmd, req_typ,
        input  s1_data, s1_data_mask, s1_kill,
        output req_ready, s2_nack, rsp_valid, rsp_tag, rsp_typ, rsp_data
    );
endinterface

// File: rtl/hella_cache_arbiter.sv
// rtl/hella_cache_arbiter.sv - two-requester round-robin hella cache arbiter with outstanding limits
module hella_cache_arbiter #(
    parameter int NUM_ADDR_BITS   = 40,
    parameter int NUM_DATA_BITS   = 64,
    parameter int NUM_TAG_BITS    = 7,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    hella_cache_arbiter_if.slave   rq0,
    hella_cache_arbiter_if.slave   rq1,
    hella_cache_arbiter_if.master  mem
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic                       prio;
    logic                       s1_vld, s1_id;
    logic                       s2_vld, s2_id;
    logic [CNT_W-1:0]           cnt0, cnt1;

    logic                       elig0, elig1, win, fire;
    logic [NUM_ADDR_BITS-1:0]   win_addr;
    logic [NUM_TAG_BITS-2:0]    win_tag;
    logic [NUM_DATA_BITS-1:0]   s1_data;
    logic [NUM_DATA_BITS/8-1:0] s1_mask;
    logic                       kill0, kill1;

    assign elig0 = rq0.req_valid && (cnt0 < CNT_MAX);
    assign elig1 = rq1.req_valid && (cnt1 < CNT_MAX);

    // The pointed-to requester keeps priority only while it is eligible.
    assign win  = prio ? elig1 : ~elig0;
    assign fire = mem.req_valid & mem.req_ready;

    assign win_addr = win ? rq1.req_addr : rq0.req_addr;
    assign win_tag  = win ? rq1.req_tag  : rq0.req_tag;

    assign mem.req_valid = elig0 | elig1;
    assign mem.req_addr  = win_addr;
    assign mem.req_tag   = {win, win_tag};
    assign mem.req_cmd   = win ? rq1.req_cmd : rq0.req_cmd;
    assign mem.req_typ   = win ? rq1.req_typ : rq0.req_typ;

    assign rq0.req_ready = ~win & fire;
    assign rq1.req_ready =  win & fire;

    assign s1_data = s1_id ? rq1.s1_data      : rq0.s1_data;
    assign s1_mask = s1_id ? rq1.s1_data_mask : rq0.s1_data_mask;

    assign mem.s1_data      = s1_data;
    assign mem.s1_data_mask = s1_mask;
    assign mem.s1_kill      = s1_vld & (s1_id ? rq1.s1_kill : rq0.s1_kill);

    assign kill0 = mem.s1_kill & ~s1_id;
    assign kill1 = mem.s1_kill &  s1_id;

    assign rq0.s2_nack = mem.s2_nack & s2_vld & ~s2_id;
    assign rq1.s2_nack = mem.s2_nack & s2_vld &  s2_id;

    // Responses are steered by the id bit the arbiter prepended to the tag.
    assign rq0.rsp_valid = mem.rsp_valid & ~mem.rsp_tag[NUM_TAG_BITS-1];
    assign rq1.rsp_valid = mem.rsp_valid &  mem.rsp_tag[NUM_TAG_BITS-1];
    assign rq0.rsp_tag   = mem.rsp_tag[NUM_TAG_BITS-2:0];
    assign rq1.rsp_tag   = mem.rsp_tag[NUM_TAG_BITS-2:0];
    assign rq0.rsp_typ   = mem.rsp_typ;
    assign rq1.rsp_typ   = mem.rsp_typ;
    assign rq0.rsp_data  = mem.rsp_data;
    assign rq1.rsp_data  = mem.rsp_data;

    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             dec_kill,
        input logic             dec_nack,
        input logic             dec_rsp
    );
        logic [CNT_W+1:0] up;
        logic [CNT_W+1:0] down;
        up   = {2'b00, c} + (CNT_W+2)'(inc);
        down = (CNT_W+2)'(dec_kill) + (CNT_W+2)'(dec_nack) + (CNT_W+2)'(dec_rsp);
        if (up <= down)
            return '0;
        else if ((up - down) >= (CNT_W+2)'(MAX_OUTSTANDING))
            return CNT_MAX;
        else
            return CNT_W'(up - down);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio   <= 1'b0;
            s1_vld <= 1'b0;
            s1_id  <= 1'b0;
            s2_vld <= 1'b0;
            s2_id  <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            if (fire)
                prio <= ~win;
            s1_vld <= fire;
            s1_id  <= win;
            s2_vld <= s1_vld & ~mem.s1_kill;
            s2_id  <= s1_id;
            cnt0   <= next_cnt(cnt0, fire & ~win, kill0, rq0.s2_nack, rq0.rsp_valid);
            cnt1   <= next_cnt(cnt1, fire &  win, kill1, rq1.s2_nack, rq1.rsp_valid);
        end
    end
endmodule

// File: tb/tb_hella_cache_arbiter.sv
// tb/tb_hella_cache_arbiter.sv - self-checking bench for hella_cache_arbiter
module tb_hella_cache_arbiter;
    localparam int MAXO = 4;

    logic clk;
    logic rst_n;

    hella_cache_arbiter_if #(.ADDR_BITS(40), .DATA_BITS(64), .TAG_BITS(6)) i0 ();
    hella_cache_arbiter_if #(.ADDR_BITS(40), .DATA_BITS(64), .TAG_BITS(6)) i1 ();
    hella_cache_arbiter_if #(.ADDR_BITS(40), .DATA_BITS(64), .TAG_BITS(7)) im ();

    hella_cache_arbiter #(
        .NUM_ADDR_BITS(40), .NUM_DATA_BITS(64), .NUM_TAG_BITS(7), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clk), .reset(rst_n), .rq0(i0.slave), .rq1(i1.slave), .mem(im.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: outstanding counts, round-robin pointer, and which requester owns each pipeline stage (-1 = empty).
    int  cnt [2];
    int  prio;
    int  s1_owner, s2_owner;
    bit  m_fire;
    int  m_win;
    bit  kill_evt [2];
    bit  nack_evt [2];
    bit  rsp_evt  [2];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            miscompares++;
        end
    endfunction

    function automatic void model_reset();
        cnt[0] = 0; cnt[1] = 0; prio = 0; s1_owner = -1; s2_owner = -1;
    endfunction

    task automatic drive_idle();
        i0.req_valid = 0; i1.req_valid = 0;
        i0.req_addr = {$urandom, $urandom}; i1.req_addr = {$urandom, $urandom};
        i0.req_tag = 6'($urandom); i1.req_tag = 6'($urandom);
        i0.req_cmd = 5'($urandom); i1.req_cmd = 5'($urandom);
        i0.req_typ = 3'($urandom); i1.req_typ = 3'($urandom);
        i0.s1_data = {$urandom, $urandom}; i1.s1_data = {$urandom, $urandom};
        i0.s1_data_mask = 8'($urandom); i1.s1_data_mask = 8'($urandom);
        i0.s1_kill = 0; i1.s1_kill = 0;
        im.req_ready = 0; im.s2_nack = 0; im.rsp_valid = 0;
        im.rsp_tag = 7'($urandom); im.rsp_typ = 3'($urandom); im.rsp_data = {$urandom, $urandom};
    endtask

    task automatic apply();
        bit elig [2];
        bit any;
        logic [63:0] tag_e;
        #1;
        vectors++;
        elig[0] = i0.req_valid && (cnt[0] < MAXO);
        elig[1] = i1.req_valid && (cnt[1] < MAXO);
        m_win  = elig[prio] ? prio : 1 - prio;
        any    = elig[0] || elig[1];
        m_fire = any && im.req_ready;
        chk("mem_req_valid", 64'(im.req_valid), 64'(any));
        if (any) begin
            tag_e = 64'(m_win * 64) + 64'(m_win == 1 ? i1.req_tag : i0.req_tag);
            chk("mem_req_addr", 64'(im.req_addr), 64'(m_win == 1 ? i1.req_addr : i0.req_addr));
            chk("mem_req_tag", 64'(im.req_tag), tag_e);
            chk("mem_req_cmd", 64'(im.req_cmd), 64'(m_win == 1 ? i1.req_cmd : i0.req_cmd));
            chk("mem_req_typ", 64'(im.req_typ), 64'(m_win == 1 ? i1.req_typ : i0.req_typ));
        end
        chk("rq0_req_ready", 64'(i0.req_ready), 64'(m_fire && m_win == 0));
        chk("rq1_req_ready", 64'(i1.req_ready), 64'(m_fire && m_win == 1));
        kill_evt[0] = (s1_owner == 0) && i0.s1_kill;
        kill_evt[1] = (s1_owner == 1) && i1.s1_kill;
        chk("mem_s1_kill", 64'(im.s1_kill), 64'(kill_evt[0] || kill_evt[1]));
        if (s1_owner >= 0) begin
            chk("mem_s1_data", im.s1_data, s1_owner == 1 ? i1.s1_data : i0.s1_data);
            chk("mem_s1_mask", 64'(im.s1_data_mask), 64'(s1_owner == 1 ? i1.s1_data_mask : i0.s1_data_mask));
        end
        for (int i = 0; i < 2; i++) begin
            nack_evt[i] = im.s2_nack && (s2_owner == i);
            rsp_evt[i]  = im.rsp_valid && (int'(im.rsp_tag[6]) == i);
        end
        chk("rq0_rsp_nack", 64'(i0.s2_nack), 64'(nack_evt[0]));
        chk("rq1_rsp_nack", 64'(i1.s2_nack), 64'(nack_evt[1]));
        chk("rq0_rsp_valid", 64'(i0.rsp_valid), 64'(rsp_evt[0]));
        chk("rq1_rsp_valid", 64'(i1.rsp_valid), 64'(rsp_evt[1]));
        chk("rq0_rsp_tag", 64'(i0.rsp_tag), 64'(im.rsp_tag) % 64);
        chk("rq1_rsp_tag", 64'(i1.rsp_tag), 64'(im.rsp_tag) % 64);
        chk("rq0_rsp_typ", 64'(i0.rsp_typ), 64'(im.rsp_typ));
        chk("rq1_rsp_typ", 64'(i1.rsp_typ), 64'(im.rsp_typ));
        chk("rq0_rsp_data", i0.rsp_data, im.rsp_data);
        chk("rq1_rsp_data", i1.rsp_data, im.rsp_data);
    endtask

    task automatic tick();
        int d;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                d = int'(m_fire && m_win == i) - int'(kill_evt[i]) - int'(nack_evt[i]) - int'(rsp_evt[i]);
                cnt[i] = cnt[i] + d;
                if (cnt[i] < 0) cnt[i] = 0;
                if (cnt[i] > MAXO) cnt[i] = MAXO;
            end
            s2_owner = (s1_owner >= 0 && !(kill_evt[0] || kill_evt[1])) ? s1_owner : -1;
            s1_owner = m_fire ? m_win : -1;
            if (m_fire) prio = 1 - m_win;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        im.req_ready = 0; im.s2_nack = 0; im.rsp_valid = 0;
        rst_n = 0;
        model_reset();
        apply();
        chk("rst_rq0_ready", 64'(i0.req_ready), 64'd0);
        tick();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        model_reset();
        drive_idle();
        @(negedge clk);
        do_reset();

        // Round robin from reset: 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            drive_idle();
            i0.req_valid = 1; i1.req_valid = 1; im.req_ready = 1;
            apply();
            chk("rr_tag_msb", 64'(im.req_tag[6]), 64'(k % 2));
            chk("rr_rq0_ready", 64'(i0.req_ready), 64'((k + 1) % 2));
            tick();
        end

        // Backpressure: requester 0 alone, tag 0x15
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_idle();
            i0.req_valid = 1; i0.req_tag = 6'h15; im.req_ready = (k == 3);
            apply();
            chk("bp_valid", 64'(im.req_valid), 64'd1);
            chk("bp_tag", 64'(im.req_tag), 64'h15);
            chk("bp_rq0_ready", 64'(i0.req_ready), 64'(k == 3));
            tick();
        end

        // Stage-1 kill from requester 1
        do_reset();
        drive_idle(); i1.req_valid = 1; im.req_ready = 1; apply(); tick();
        drive_idle(); i1.s1_kill = 1; apply();
        chk("kill_mem_s1_kill", 64'(im.s1_kill), 64'd1);
        tick();
        drive_idle(); im.s2_nack = 1; apply();
        chk("kill_no_s2_nack", 64'(i1.s2_nack), 64'd0);
        tick();

        // Stage-2 nack to requester 0, then count must allow exactly 4 more
        do_reset();
        drive_idle(); i0.req_valid = 1; im.req_ready = 1; apply(); tick();
        drive_idle(); apply(); tick();
        drive_idle(); im.s2_nack = 1; apply();
        chk("nack_rq0", 64'(i0.s2_nack), 64'd1);
        chk("nack_rq1", 64'(i1.s2_nack), 64'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive_idle(); i0.req_valid = 1; im.req_ready = 1; apply();
            chk("nack_refill_ready", 64'(i0.req_ready), 64'(k < 4));
            tick();
        end

        // Outstanding limit on requester 1, released by a response tagged 0x45
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_idle(); i1.req_valid = 1; im.req_ready = 1; apply(); tick();
        end
        drive_idle(); i0.req_valid = 1; i1.req_valid = 1; im.req_ready = 1; apply();
        chk("lim_rq1_blocked", 64'(i1.req_ready), 64'd0);
        chk("lim_rq0_granted", 64'(i0.req_ready), 64'd1);
        tick();
        drive_idle(); i1.req_valid = 1; im.req_ready = 1; im.rsp_valid = 1; im.rsp_tag = 7'h45; apply();
        chk("lim_rsp_valid", 64'(i1.rsp_valid), 64'd1);
        chk("lim_rsp_tag", 64'(i1.rsp_tag), 64'h05);
        chk("lim_still_blocked", 64'(i1.req_ready), 64'd0);
        tick();
        drive_idle(); i1.req_valid = 1; im.req_ready = 1; apply();
        chk("lim_fifth_granted", 64'(i1.req_ready), 64'd1);
        tick();

        // Asynchronous reset mid-burst with two outstanding on requester 0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive_idle(); i0.req_valid = 1; im.req_ready = 1; apply(); tick();
        end
        drive_idle(); i0.s1_kill = 1; im.s2_nack = 1; apply();
        chk("ar_pre_kill", 64'(im.s1_kill), 64'd1);
        chk("ar_pre_nack", 64'(i0.s2_nack), 64'd1);
        #1 rst_n = 0;
        #1;
        chk("ar_kill_cleared", 64'(im.s1_kill), 64'd0);
        chk("ar_nack_cleared", 64'(i0.s2_nack), 64'd0);
        model_reset();
        im.s2_nack = 0;
        tick();
        rst_n = 1;
        drive_idle(); i0.req_valid = 1; i1.req_valid = 1; im.req_ready = 1; apply();
        chk("ar_prio0", 64'(i0.req_ready), 64'd1);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive_idle();
                do_reset();
            end else begin
                drive_idle();
                i0.req_valid = ($urandom_range(0, 9) < 7);
                i1.req_valid = ($urandom_range(0, 9) < 7);
                im.req_ready = ($urandom_range(0, 9) < 6);
                i0.s1_kill = ($urandom_range(0, 9) == 0);
                i1.s1_kill = ($urandom_range(0, 9) == 0);
                im.s2_nack = ($urandom_range(0, 9) == 0);
                im.rsp_valid = ($urandom_range(0, 9) < 3);
                apply();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
